burst_ram: RTL and testbench

BURST_RAM -- requirements
Module: burst_ram

---
 rtl/burst_ram_pkg.sv | 7 +
 rtl/burst_ram_bram.sv | 24 ++
 rtl/burst_ram.sv | 101 ++++++++++
 tb/tb_burst_ram.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared widths and FSM state encoding for the burst RAM model
package burst_ram_pkg;
  localparam int WordW = 64;
  localparam int MaskW = 8;
  localparam int CntW = 16;
  typedef enum logic [2:0] {INIT, IDLE, WRITE, READ_WAIT, READ} state_e;
endpackage

// File: rtl/burst_ram_bram.sv
// burst_ram_bram: single-port byte-enable RAM with one-cycle registered read
module burst_ram_bram
  import burst_ram_pkg::*;
#(
  parameter int DepthBitwidth = 12
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [MaskW-1:0]         be_i,
  input  logic [DepthBitwidth-1:0] addr_i,
  input  logic [WordW-1:0]         din_i,
  output logic [WordW-1:0]         dout_o
);
  logic [WordW-1:0] mem_q [2**DepthBitwidth];
  logic [WordW-1:0] dout_q;
  assign dout_o = dout_q;
  // byte-masked write and read-before-write registered output
  always_ff @(posedge clk) begin
    if (we_i)
      for (int i = 0; i < MaskW; i++)
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= din_i[i*8 +: 8];
    dout_q <= mem_q[addr_i];
  end
endmodule

// File: rtl/burst_ram.sv
// burst_ram: simulation stand-in for a PSRAM controller with fixed-length bursts
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int AddressBitwidth       = 21,
  parameter int DepthBitwidth         = 12,
  parameter int BurstDataCount        = 4,
  parameter int CyclesBeforeDataValid = 6,
  parameter int CyclesBeforeInitiated = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd,
  input  logic                       cmd_en,
  input  logic [AddressBitwidth-1:0] addr,
  input  logic [WordW-1:0]           wr_data,
  input  logic [MaskW-1:0]           data_mask,
  output logic [WordW-1:0]           rd_data,
  output logic                       rd_data_valid,
  output logic                       init_calib,
  output logic                       busy
);
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DepthBitwidth-1:0] ptr_q, ptr_d, idx, mem_addr;
  logic init_q, init_d, we;
  logic unused_addr;
  assign idx = addr[DepthBitwidth+2:3];
  assign unused_addr = ^{addr[2:0], addr[AddressBitwidth-1:DepthBitwidth+3]};
  assign rd_data_valid = state_q == READ;
  assign busy = state_q != IDLE;
  assign init_calib = init_q;
  // next state; the RAM address runs one word ahead in READ to hide the registered read
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CntW'(1);
    ptr_d = ptr_q;
    init_d = init_q;
    we = 1'b0;
    mem_addr = ptr_q;
    case (state_q)
      INIT: if (cnt_q == CntW'(CyclesBeforeInitiated - 1)) begin
        state_d = IDLE;
        init_d = 1'b1;
        cnt_d = '0;
      end
      IDLE: begin
        mem_addr = idx;
        cnt_d = cnt_q;
        if (cmd_en) begin
          ptr_d = idx;
          we = cmd;
          cnt_d = cmd ? CntW'(1) : '0;
          state_d = !cmd ? READ_WAIT : BurstDataCount == 1 ? IDLE : WRITE;
        end
      end
      WRITE: begin
        mem_addr = ptr_q + DepthBitwidth'(cnt_q);
        we = 1'b1;
        if (cnt_q == CntW'(BurstDataCount - 1)) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      READ_WAIT: if (cnt_q == CntW'(CyclesBeforeDataValid - 2)) begin
        state_d = READ;
        cnt_d = '0;
      end
      READ: begin
        mem_addr = ptr_q + DepthBitwidth'(cnt_q + CntW'(1));
        if (cnt_q == CntW'(BurstDataCount - 1)) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end
  // state registers; storage is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      ptr_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      init_q <= init_d;
    end
  end
  burst_ram_bram #(.DepthBitwidth(DepthBitwidth)) u_bram (
    .clk   (clk),
    .we_i  (we),
    .be_i  (~data_mask),
    .addr_i(mem_addr),
    .din_i (wr_data),
    .dout_o(rd_data)
  );
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed table plus random bursts checked against a word-array model
module tb_burst_ram;
  typedef struct packed {
    logic wr;
    logic [20:0] a;
    logic [3:0][63:0] d;
    logic [3:0][7:0] m;
    logic [3:0][63:0] e;
  } vec_t;
  logic clk = 0, rst = 1, cmd = 0, cmd_en = 0;
  logic [20:0] addr = 0;
  logic [63:0] wr_data = 0, rd_data;
  logic [7:0] data_mask = 0;
  logic rd_data_valid, init_calib, busy;
  int total = 0, bad = 0;
  logic [63:0] mem_m [4096];
  logic [7:0] kb [4096];
  vec_t tbl [8];
  logic [11:0] wi, w;
  logic [20:0] ra;
  logic [3:0][63:0] rd_d, rd_e;
  logic [3:0][7:0] rd_m;
  logic [3:0] kn;
  always #5 clk = ~clk;
  burst_ram dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [3:0][63:0] w4(input logic [63:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic init_check();
    rst = 1;
    cmd_en = 0;
    tick();
    chk("rst_init", init_calib, 0);
    chk("rst_busy", busy, 1);
    chk("rst_valid", rd_data_valid, 0);
    rst = 0;
    for (int i = 1; i <= 10; i++) begin
      cmd_en = i < 5;
      cmd = 1;
      addr = 21'h40;
      tick();
      chk("init_calib", init_calib, i == 10);
      chk("init_busy", busy, i != 10);
    end
    cmd_en = 0;
  endtask
  task automatic write_burst(input logic [20:0] a, input logic [3:0][63:0] d, input logic [3:0][7:0] m);
    logic [11:0] x;
    for (int k = 0; k < 4; k++) begin
      cmd_en = k == 0;
      cmd = 1;
      addr = a;
      wr_data = d[k];
      data_mask = m[k];
      x = a[14:3] + 12'(k);
      for (int b = 0; b < 8; b++)
        if (!m[k][b]) begin
          mem_m[x][b*8 +: 8] = d[k][b*8 +: 8];
          kb[x][b] = 1'b1;
        end
      tick();
      if (k == 0) chk("wr_busy", busy, 1);
    end
    cmd_en = 0;
    chk("wr_done_busy", busy, 0);
  endtask
  task automatic read_burst(input logic [20:0] a, input logic [3:0][63:0] e, input logic [3:0] known, input bit pulse, input int rst_at);
    int nv = 0;
    logic ev;
    cmd_en = 1;
    cmd = 0;
    addr = a;
    tick();
    for (int c = 1; c <= 10; c++) begin
      ev = c >= 6 && c <= 9 && (rst_at == 0 || c <= rst_at);
      chk("rd_valid", rd_data_valid, ev);
      if (ev && known[c-6]) chk("rd_data", rd_data, e[c-6]);
      nv += int'(rd_data_valid);
      if (c == 10 && rst_at == 0) chk("rd_done_busy", busy, 0);
      if (rst_at != 0 && c > rst_at) chk("rd_abort_busy", busy, 1);
      if (c == rst_at) rst = 1;
      cmd_en = pulse && (c == 3 || c == 7);
      cmd = 1;
      wr_data = {$urandom, $urandom};
      data_mask = 0;
      tick();
    end
    cmd_en = 0;
    rst = 0;
    chk("rd_count", nv, rst_at != 0 ? rst_at - 5 : 4);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) kb[i] = 0;
    tbl[0] = '{wr: 1, a: 21'h40, d: w4({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}), m: '0, e: '0};
    tbl[1] = '{wr: 0, a: 21'h40, d: '0, m: '0, e: w4({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}})};
    tbl[2] = '{wr: 1, a: 21'h80, d: w4('1, '1, '1, '1), m: '0, e: '0};
    tbl[3] = '{wr: 1, a: 21'h80, d: w4(64'h1122334455667788, 64'hDEAD, 64'hBEEF, 64'hCAFE), m: {8'hFF, 8'hFF, 8'hFF, 8'h0F}, e: '0};
    tbl[4] = '{wr: 0, a: 21'h80, d: '0, m: '0, e: w4(64'h11223344FFFFFFFF, '1, '1, '1)};
    tbl[5] = '{wr: 1, a: 21'h7FF8, d: w4({16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}), m: '0, e: '0};
    tbl[6] = '{wr: 0, a: 21'h7FF8, d: '0, m: '0, e: w4({16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}})};
    tbl[7] = '{wr: 0, a: 21'h10040, d: '0, m: '0, e: w4({16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}})};
    init_check();
    for (int i = 0; i < 8; i++)
      if (tbl[i].wr) write_burst(tbl[i].a, tbl[i].d, tbl[i].m);
      else read_burst(tbl[i].a, tbl[i].e, 4'hF, 0, 0);
    read_burst(21'h40, tbl[1].e, 4'hF, 1, 0);
    read_burst(21'h40, tbl[1].e, 4'hF, 0, 0);
    read_burst(21'h80, tbl[4].e, 4'hF, 0, 8);
    init_check();
    read_burst(21'h80, tbl[4].e, 4'hF, 0, 0);
    read_burst(21'h7FF8, tbl[6].e, 4'hF, 0, 0);
    for (int n = 0; n < 60; n++) begin
      wi = $urandom_range(0, 1) ? 12'($urandom_range(0, 7)) : 12'(4092 + $urandom_range(0, 3));
      ra = {6'($urandom), wi, 3'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) begin
          rd_d[k] = {$urandom, $urandom};
          rd_m[k] = $urandom_range(0, 3) == 0 ? 8'($urandom) : $urandom_range(0, 5) == 0 ? 8'hFF : 8'h00;
        end
        write_burst(ra, rd_d, rd_m);
      end else begin
        for (int k = 0; k < 4; k++) begin
          w = wi + 12'(k);
          rd_e[k] = mem_m[w];
          kn[k] = kb[w] == 8'hFF;
        end
        read_burst(ra, rd_e, kn, $urandom_range(0, 3) == 0, 0);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
